// File: rtl/hex_scroll_engine_pkg.sv
// Shared character codes, segment constants and the 64-entry code-to-segment table
// for the scrolling 7-segment message engine.
package hex_scroll_pkg;

    localparam logic [5:0] CH_0     = 6'd0;
    localparam logic [5:0] CH_A     = 6'd10;
    localparam logic [5:0] CH_DASH  = 6'd36;
    localparam logic [5:0] CH_BLANK = 6'd63;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low g..a patterns; letters without a true 7-seg form use the closest shape.
    function automatic logic [6:0] seg_lookup(input logic [5:0] code);
        logic [6:0] s;
        case (code)
            6'd0:  s = 7'b1000000;
            6'd1:  s = 7'b1111001;
            6'd2:  s = 7'b0100100;
            6'd3:  s = 7'b0110000;
            6'd4:  s = 7'b0011001;
            6'd5:  s = 7'b0010010;
            6'd6:  s = 7'b0000010;
            6'd7:  s = 7'b1111000;
            6'd8:  s = 7'b0000000;
            6'd9:  s = 7'b0010000;
            6'd10: s = 7'b0001000;
            6'd11: s = 7'b0000011;
            6'd12: s = 7'b1000110;
            6'd13: s = 7'b0100001;
            6'd14: s = 7'b0000110;
            6'd15: s = 7'b0001110;
            6'd16: s = 7'b1000010;
            6'd17: s = 7'b0001001;
            6'd18: s = 7'b1111001;
            6'd19: s = 7'b1100001;
            6'd20: s = 7'b0001010;
            6'd21: s = 7'b1000111;
            6'd22: s = 7'b1101010;
            6'd23: s = 7'b0101011;
            6'd24: s = 7'b1000000;
            6'd25: s = 7'b0001100;
            6'd26: s = 7'b0011000;
            6'd27: s = 7'b0101111;
            6'd28: s = 7'b0010010;
            6'd29: s = 7'b0000111;
            6'd30: s = 7'b1000001;
            6'd31: s = 7'b1100011;
            6'd32: s = 7'b1010101;
            6'd33: s = 7'b0001001;
            6'd34: s = 7'b0010001;
            6'd35: s = 7'b0100100;
            6'd36: s = 7'b0111111;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex_scroll_engine_if.sv
// Control/write bus and display outputs of the scroll engine, grouped for port hookup.
interface hex_scroll_engine_if #(
    parameter int unsigned MSG_LEN = 32
);
    localparam int unsigned AW = $clog2(MSG_LEN);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [5:0]    wr_char;
    logic [AW:0]   msg_len;
    logic          run;
    logic          dir;
    logic [1:0]    speed;
    logic          step_now;
    logic [6:0]    HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;
    logic [AW-1:0] pos;
    logic          wrap;

    modport master (
        output wr_en, wr_addr, wr_char, msg_len, run, dir, speed, step_now,
        input  HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, pos, wrap
    );

    modport slave (
        input  wr_en, wr_addr, wr_char, msg_len, run, dir, speed, step_now,
        output HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, pos, wrap
    );

endinterface

// File: rtl/hex_scroll_engine_seg7_char_dec.sv
// Combinational character-code to active-low 7-segment decoder.
module seg7_char_dec
    import hex_scroll_pkg::*;
(
    input  logic [5:0] code,
    output logic [6:0] seg_c
);

    assign seg_c = seg_lookup(code);

endmodule

// File: rtl/hex_scroll_engine.sv
// Message buffer plus scrolling 6-character window driving HEX5..HEX0, with prescaled
// auto-step and edge-detected manual step.
module hex_scroll_engine
    import hex_scroll_pkg::*;
#(
    parameter int unsigned MSG_LEN  = 32,
    parameter int unsigned STEP_DIV = 12_500_000
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    hex_scroll_engine_if.slave bus
);

    localparam int unsigned AW = $clog2(MSG_LEN);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2((STEP_DIV << 3) + 1);

    logic [5:0]    buf_q [MSG_LEN];
    logic [AW-1:0] pos_q;
    logic [CW-1:0] cnt_q;
    logic          sn_q;
    logic          wrap_q;
    logic [6:0]    hex_q [6];

    logic [LW-1:0] len_c;
    logic [LW-1:0] pos_ext_c;
    logic [CW-1:0] lim_c;
    logic          tick_c;
    logic          step_c;
    logic [LW-1:0] idx_c [6];
    logic [LW-1:0] walk_c;
    logic [5:0]    code_c [6];
    logic [6:0]    seg_c [6];

    // Effective length and step sources
    always_comb begin
        len_c     = (bus.msg_len > LW'(MSG_LEN)) ? LW'(MSG_LEN) : bus.msg_len;
        pos_ext_c = {1'b0, pos_q};
        lim_c     = CW'(STEP_DIV) << bus.speed;
        tick_c    = bus.run && (cnt_q >= (lim_c - CW'(1)));
        step_c    = tick_c || (bus.step_now && !sn_q);
    end

    // Window indices walk forward from pos with a single wrap compare per digit,
    // so lengths below six simply repeat.
    always_comb begin
        walk_c = (pos_ext_c >= len_c) ? '0 : pos_ext_c;
        for (int i = 0; i < 6; i++) begin
            idx_c[i]  = walk_c;
            code_c[i] = (len_c == '0) ? CH_BLANK : buf_q[idx_c[i][AW-1:0]];
            walk_c    = walk_c + LW'(1);
            if (walk_c >= len_c) begin
                walk_c = '0;
            end
        end
    end

    for (genvar g = 0; g < 6; g++) begin : g_dec
        seg7_char_dec u_dec (
            .code  (code_c[g]),
            .seg_c (seg_c[g])
        );
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            for (int i = 0; i < int'(MSG_LEN); i++) begin
                buf_q[i] <= CH_BLANK;
            end
            for (int i = 0; i < 6; i++) begin
                hex_q[i] <= SEG_BLANK;
            end
            pos_q  <= '0;
            cnt_q  <= '0;
            sn_q   <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            sn_q <= bus.step_now;
            if (bus.run) begin
                cnt_q <= tick_c ? '0 : cnt_q + CW'(1);
            end
            if (bus.wr_en && ({1'b0, bus.wr_addr} < LW'(MSG_LEN))) begin
                buf_q[bus.wr_addr] <= bus.wr_char;
            end
            for (int i = 0; i < 6; i++) begin
                hex_q[i] <= seg_c[i];
            end
            wrap_q <= 1'b0;
            // Out-of-range pos (including L=0) recovers to 0 and swallows any step.
            if (pos_ext_c >= len_c) begin
                pos_q <= '0;
            end else if (step_c) begin
                if (!bus.dir) begin
                    if (pos_ext_c == len_c - LW'(1)) begin
                        pos_q  <= '0;
                        wrap_q <= 1'b1;
                    end else begin
                        pos_q <= pos_q + AW'(1);
                    end
                end else begin
                    if (pos_q == '0) begin
                        pos_q  <= AW'(len_c - LW'(1));
                        wrap_q <= 1'b1;
                    end else begin
                        pos_q <= pos_q - AW'(1);
                    end
                end
            end
        end
    end

    assign bus.HEX5 = hex_q[0];
    assign bus.HEX4 = hex_q[1];
    assign bus.HEX3 = hex_q[2];
    assign bus.HEX2 = hex_q[3];
    assign bus.HEX1 = hex_q[4];
    assign bus.HEX0 = hex_q[5];
    assign bus.pos  = pos_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_hex_scroll_engine.sv
// Scoreboard bench for hex_scroll_engine: directed scenarios plus random traffic,
// checked every cycle against a behavioural model.
module tb_hex_scroll_engine;

    localparam int ML = 30;
    localparam int SD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hex_scroll_engine_if #(.MSG_LEN(ML)) bus ();

    hex_scroll_engine #(.MSG_LEN(ML), .STEP_DIV(SD)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .bus      (bus.slave)
    );

    typedef struct {
        int          pos;
        bit          wrap;
        logic [41:0] hex;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    int          m_buf [ML];
    int          m_pos;
    int          m_cnt;
    bit          m_snq;
    logic [41:0] m_hex;
    bit          m_wrap;

    function automatic logic [6:0] ref_seg(input int c);
        case (c)
            0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
            3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
            9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
           12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110;
           15: return 7'b0001110; 16: return 7'b1000010; 17: return 7'b0001001;
           18: return 7'b1111001; 19: return 7'b1100001; 20: return 7'b0001010;
           21: return 7'b1000111; 22: return 7'b1101010; 23: return 7'b0101011;
           24: return 7'b1000000; 25: return 7'b0001100; 26: return 7'b0011000;
           27: return 7'b0101111; 28: return 7'b0010010; 29: return 7'b0000111;
           30: return 7'b1000001; 31: return 7'b1100011; 32: return 7'b1010101;
           33: return 7'b0001001; 34: return 7'b0010001; 35: return 7'b0100100;
           36: return 7'b0111111;
           default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act !== req) $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        else n_pass++;
    endtask

    // Predict the state after the coming clock edge from the inputs now applied.
    task automatic model_update();
        exp_t e;
        int   len, base, lim;
        bit   tick, stp;
        if (rst) begin
            foreach (m_buf[i]) m_buf[i] = 63;
            m_pos = 0; m_cnt = 0; m_snq = 0; m_wrap = 0;
            m_hex = {6{7'h7F}};
        end else begin
            len = (int'(bus.msg_len) > ML) ? ML : int'(bus.msg_len);
            base = (m_pos >= len) ? 0 : m_pos;
            for (int k = 0; k < 6; k++)
                m_hex[k*7 +: 7] = (len == 0) ? 7'h7F : ref_seg(m_buf[(base + 5 - k) % len]);
            lim = SD << bus.speed;
            tick = 0;
            if (bus.run) begin
                if (m_cnt >= lim - 1) begin m_cnt = 0; tick = 1; end
                else m_cnt++;
            end
            stp = tick || (bus.step_now && !m_snq);
            m_snq = bus.step_now;
            m_wrap = 0;
            if (m_pos >= len) m_pos = 0;
            else if (stp) begin
                if (!bus.dir) begin m_pos = (m_pos + 1) % len;       m_wrap = (m_pos == 0); end
                else          begin m_pos = (m_pos + len - 1) % len; m_wrap = (m_pos == len - 1); end
            end
            if (bus.wr_en && int'(bus.wr_addr) < ML) m_buf[bus.wr_addr] = int'(bus.wr_char);
        end
        e.pos = m_pos; e.wrap = m_wrap; e.hex = m_hex;
        exp_q.push_back(e);
    endtask

    task automatic step_cycle();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: every cycle the DUT presents a new output word.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_pos",  64'(bus.pos), 64'(e.pos));
            chk("sb_wrap", 64'(bus.wrap), 64'(e.wrap));
            chk("sb_hex",  64'({bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0}), 64'(e.hex));
        end
    end

    task automatic write_char(input int a, input int c);
        bus.wr_en = 1; bus.wr_addr = 5'(a); bus.wr_char = 6'(c);
        step_cycle();
        bus.wr_en = 0;
    endtask

    initial begin
        int scroll[6];
        int wraps, moves, prev, old, guard;
        scroll = '{28, 12, 27, 24, 21, 21};
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_char = '0; bus.msg_len = '0;
        bus.run = 0; bus.dir = 0; bus.speed = '0; bus.step_now = 0;
        @(negedge clk);

        // Reset
        rst = 1; step_cycle(); step_cycle();
        chk("rst_hex", 64'({bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0}), 64'({6{7'h7F}}));
        chk("rst_pos", 64'(bus.pos), 64'd0);
        chk("rst_wrap", 64'(bus.wrap), 64'd0);
        rst = 0;

        // SCROLL message
        bus.msg_len = 6'd6;
        for (int i = 0; i < 6; i++) write_char(i, scroll[i]);
        step_cycle();
        chk("scroll_hex5", 64'(bus.HEX5), 64'(7'b0010010));
        chk("scroll_hex0", 64'(bus.HEX0), 64'(7'b1000111));

        // Auto-scroll at speed 0 then speed 2
        bus.msg_len = 6'd8; bus.run = 1;
        wraps = 0;
        for (int i = 0; i < 64; i++) begin step_cycle(); if (bus.wrap) wraps++; end
        chk("wraps_64cyc", 64'(wraps), 64'd2);
        bus.speed = 2'd2;
        moves = 0; prev = int'(bus.pos);
        for (int i = 0; i < 64; i++) begin
            step_cycle();
            if (int'(bus.pos) != prev) moves++;
            prev = int'(bus.pos);
        end
        chk("steps_speed2", 64'(moves), 64'd4);
        bus.run = 0; bus.speed = 2'd0;

        // Reverse manual step wrapping from 0
        bus.msg_len = 6'd0; step_cycle();
        bus.msg_len = 6'd8; bus.dir = 1; bus.step_now = 1; step_cycle();
        chk("rev_pos", 64'(bus.pos), 64'd7);
        chk("rev_wrap", 64'(bus.wrap), 64'd1);
        for (int i = 0; i < 3; i++) step_cycle();
        chk("hold_pos", 64'(bus.pos), 64'd7);
        chk("hold_wrap", 64'(bus.wrap), 64'd0);

        // Advance to pos 5 then shrink to 3
        bus.dir = 0;
        for (int i = 0; i < 6; i++) begin
            bus.step_now = 0; step_cycle();
            bus.step_now = 1; step_cycle();
        end
        bus.step_now = 0;
        chk("pos5", 64'(bus.pos), 64'd5);
        bus.msg_len = 6'd3; step_cycle();
        chk("shrink_pos", 64'(bus.pos), 64'd0);
        chk("shrink_wrap", 64'(bus.wrap), 64'd0);
        step_cycle();
        chk("shrink_hex5", 64'(bus.HEX5), 64'(7'b0010010));
        chk("shrink_hex3", 64'(bus.HEX3), 64'(7'b0101111));
        chk("shrink_hex2", 64'(bus.HEX2), 64'(7'b0010010));
        bus.msg_len = 6'd0; step_cycle();
        chk("len0_hex", 64'({bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0}), 64'({6{7'h7F}}));

        // Tick coinciding with a manual edge
        bus.msg_len = 6'd8; bus.run = 1;
        guard = 0;
        while (m_cnt != SD - 1 && guard < 20) begin step_cycle(); guard++; end
        chk("align_guard", 64'(guard < 20), 64'd1);
        old = m_pos;
        bus.step_now = 1; step_cycle();
        chk("tick_edge_pos", 64'(bus.pos), 64'((old + 1) % 8));
        bus.step_now = 0; bus.run = 0;
        write_char(ML, 0);
        step_cycle();

        // Mid-scroll reset
        bus.run = 1;
        for (int i = 0; i < 10; i++) step_cycle();
        rst = 1; step_cycle(); step_cycle();
        chk("rst2_hex", 64'({bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0}), 64'({6{7'h7F}}));
        chk("rst2_pos", 64'(bus.pos), 64'd0);
        rst = 0;

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            bus.wr_en    = ($urandom_range(0, 9) < 3);
            bus.wr_addr  = 5'($urandom_range(0, 31));
            bus.wr_char  = 6'($urandom_range(0, 63));
            bus.step_now = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) bus.msg_len = 6'($urandom_range(0, 40));
            if ($urandom_range(0, 99) == 0) bus.run = ~bus.run;
            if ($urandom_range(0, 59) == 0) bus.dir = ~bus.dir;
            if ($urandom_range(0, 199) == 0) bus.speed = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 299) == 0);
            step_cycle();
        end
        rst = 0;
        step_cycle();
        @(posedge clk); #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
